mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req/m1_req  input  1  access request, held high until matching ack.
REQ-006 SHALL have ports m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_mode/m1_mode  input  2  00 word, 01 signed byte, 10 unsigned byte.
REQ-008 SHALL have ports m0_addr/m1_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have ports m0_wdata/m1_wdata  input  WIDTH  write data.
REQ-010 SHALL have ports m0_ack/m1_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  WIDTH  read data, valid while any ack is high.
REQ-012 SHALL have port err  output  1  valid with ack; 1 = request rejected.
REQ-013 SHALL have ports mem_write/mem_mode/mem_addr/mem_wdata  output  1/2/ADDR_WIDTH/WIDTH  shared memory port (MemWrite, MemMode, memAddr, memWriteData).
REQ-014 SHALL have port mem_rdata  input  WIDTH  combinational read data from memory.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one transaction at a time.
REQ-017 In IDLE with any req high, SHALL select a winner, latch its we/mode/addr/wdata, and enter ACCESS next cycle.
REQ-018 In ACCESS (exactly 1 cycle), SHALL drive mem_* from latched fields; mem_write = latched we and not rejected.
REQ-019 At end of ACCESS, SHALL register mem_rdata into rdata for reads; for writes rdata SHALL be 0.
REQ-020 In RESP, SHALL pulse the winner's ack for exactly 1 cycle, then return to IDLE.
REQ-021 Latency: req sampled in cycle N -> ack in cycle N+2; back-to-back grants every 3 cycles.
REQ-022 Outside ACCESS, mem_write, mem_mode, mem_addr, mem_wdata SHALL be 0.
REQ-023 Reject (err=1, no mem_write, rdata=0) when: mode = 11; mode 00 with addr[1:0] != 0; we=1 with mode != 00.
REQ-024 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-025 Changes on a requester's inputs after latching SHALL NOT affect the in-flight transaction.
REQ-026 m0_ack and m1_ack SHALL never be high in the same cycle.

Reset
REQ-027 On reset: state IDLE; m0_ack, m1_ack, err, busy, rdata, all mem_* outputs 0; last-grant register = m1.
REQ-028 Reset in ACCESS or RESP SHALL abort: no ack pulse issued, mem_write 0 in the following cycle.

Configuration
REQ-029 Macro MEM_ARBITER_RR_EN defined: round-robin; on simultaneous requests grant the master not granted last; last-grant updates on each grant.
REQ-030 Macro MEM_ARBITER_RR_EN undefined: fixed priority, m0 always wins simultaneous requests; no last-grant register.

Verification
REQ-031 Single m0 read: m0 addr 0x1004, mode 00, mem_rdata 0xDEADBEEF -> m0_ack at N+2, rdata 0xDEADBEEF, err 0.
REQ-032 m1 write: addr 0xFFFC, wdata 0x5A, mode 00 -> mem_write high exactly 1 cycle (N+1) with mem_addr 0xFFFC, m1_ack at N+2.
REQ-033 Both req high continuously, RR_EN defined -> grants m0, m1, m0, m1 at 3-cycle spacing; undefined -> m0 only until m0_req drops.
REQ-034 Misaligned word write addr 0x1002 -> mem_write never asserted, ack at N+2 with err 1, rdata 0.
REQ-035 Reset asserted in ACCESS cycle -> no ack, busy 0 and mem_write 0 next cycle, new request granted normally after reset.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: two-master arbiter onto one shared memory port; IDLE -> ACCESS -> RESP.
// Define MEM_ARBITER_RR_EN for round-robin grants; otherwise m0 has fixed priority.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [1:0]            m0_mode,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0]      m0_wdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [1:0]            m1_mode,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0]      m1_wdata,
  output logic                  m1_ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err,
  output logic                  busy,
  output logic                  mem_write,
  output logic [1:0]            mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  r_state, w_next;
  logic                    r_sel, r_we, r_rej;
  logic [1:0]              r_mode;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]        r_wdata, r_rdata;

  logic                    w_grant, w_sel, w_we, w_rej, w_latch, w_access;
  logic [1:0]              w_mode;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [WIDTH-1:0]        w_wdata;

  assign w_grant = m0_req | m1_req;
  assign w_latch = (r_state == S_IDLE) && w_grant;

`ifdef MEM_ARBITER_RR_EN
  logic r_last;  // 1 = m1 was granted last

  assign w_sel = (m0_req && m1_req) ? ~r_last : m1_req;

  always_ff @(posedge clk) begin
    if (reset)        r_last <= 1'b1;
    else if (w_latch) r_last <= w_sel;
  end
`else
  assign w_sel = ~m0_req;
`endif

  assign w_we    = w_sel ? m1_we    : m0_we;
  assign w_mode  = w_sel ? m1_mode  : m0_mode;
  assign w_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_wdata = w_sel ? m1_wdata : m0_wdata;

  // Bad mode, misaligned word, or sub-word write: never reaches memory.
  assign w_rej = (w_mode == 2'b11) ||
                 ((w_mode == 2'b00) && (w_addr[1:0] != 2'b00)) ||
                 (w_we && (w_mode != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel   <= 1'b0;
      r_we    <= 1'b0;
      r_rej   <= 1'b0;
      r_mode  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_sel   <= w_sel;
      r_we    <= w_we;
      r_rej   <= w_rej;
      r_mode  <= w_mode;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                      r_rdata <= '0;
    else if (r_state == S_ACCESS)   r_rdata <= (r_we || r_rej) ? '0 : mem_rdata;
  end

  assign w_access  = (r_state == S_ACCESS);
  assign mem_write = w_access & r_we & ~r_rej;
  assign mem_mode  = w_access ? r_mode  : 2'b00;
  assign mem_addr  = w_access ? r_addr  : '0;
  assign mem_wdata = w_access ? r_wdata : '0;

  assign m0_ack = (r_state == S_RESP) & ~r_sel;
  assign m1_ack = (r_state == S_RESP) &  r_sel;
  assign err    = (r_state == S_RESP) &  r_rej;
  assign busy   = (r_state != S_IDLE);
  assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: scoreboard bench; expected acks and memory writes are queued at drive time.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0]  m0_mode = 0, m1_mode = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, err, busy, mem_write;
  logic [1:0]  mem_mode;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rdata;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct { logic m; logic [31:0] rdata; logic err; int cyc; } ack_t;
  typedef struct { logic [15:0] addr; logic [31:0] wdata; int cyc; } wr_t;
  ack_t q_ack[$];
  wr_t  q_wr[$];

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_write(mem_write), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns a pattern that encodes address and mode.
  function automatic logic [31:0] memfn(input logic [15:0] a, input logic [1:0] md);
    if (a == 16'h1004) return 32'hDEADBEEF;
    return {~a, 6'b0, md, a[7:0]};
  endfunction
  assign mem_rdata = memfn(mem_addr, mem_mode);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ack_t a;
    wr_t  w;
    if (m0_ack || m1_ack) begin
      check("ack_exclusive", {63'd0, m0_ack & m1_ack}, 64'd0);
      if (q_ack.size() == 0) check("spurious_ack", 64'd1, 64'd0);
      else begin
        a = q_ack.pop_front();
        check("ack_master", {63'd0, m1_ack}, {63'd0, a.m});
        check("ack_cycle", cyc, a.cyc);
        check("rdata", rdata, a.rdata);
        check("err", {63'd0, err}, {63'd0, a.err});
      end
    end
    if (mem_write) begin
      if (q_wr.size() == 0) check("spurious_write", 64'd1, 64'd0);
      else begin
        w = q_wr.pop_front();
        check("wr_addr", mem_addr, w.addr);
        check("wr_data", mem_wdata, w.wdata);
        check("wr_cycle", cyc, w.cyc);
      end
    end
    if (!busy) check("idle_mem_zero", {mem_write, mem_mode, mem_addr, mem_wdata}, 64'd0);
  end

  task automatic drive(input bit m, input bit req, input bit we, input logic [1:0] md,
                       input logic [15:0] a, input logic [31:0] wd);
    if (m) begin m1_req = req; m1_we = we; m1_mode = md; m1_addr = a; m1_wdata = wd; end
    else   begin m0_req = req; m0_we = we; m0_mode = md; m0_addr = a; m0_wdata = wd; end
  endtask

  task automatic xact(input bit m, input bit we, input logic [1:0] md,
                      input logic [15:0] a, input logic [31:0] wd);
    bit   rej, got;
    ack_t e;
    wr_t  w;
    rej = (md == 2'b11) || ((md == 2'b00) && (a[1:0] != 2'b00)) || (we && (md != 2'b00));
    @(posedge clk); #1;
    drive(m, 1'b1, we, md, a, wd);
    e.m = m; e.err = rej; e.rdata = (rej || we) ? 32'd0 : memfn(a, md); e.cyc = cyc + 2;
    q_ack.push_back(e);
    if (we && !rej) begin w.addr = a; w.wdata = wd; w.cyc = cyc + 1; q_wr.push_back(w); end
    @(posedge clk); #1;
    drive(m, 1'b1, ~we, md ^ 2'b01, ~a, ~wd);  // in-flight transaction must ignore this
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (m ? m1_ack : m0_ack) got = 1'b1;
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 2'b00, 16'd0, 32'd0);
  endtask

  initial begin
    int   c0;
    ack_t e;
    wr_t  w;
    bit   seq [5];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {m0_ack, m1_ack, err, busy, mem_write, mem_mode, mem_addr}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    xact(1'b0, 1'b0, 2'b00, 16'h1004, 32'h0);          // word read
    xact(1'b1, 1'b1, 2'b00, 16'hFFFC, 32'h0000005A);   // word write
    xact(1'b0, 1'b1, 2'b00, 16'h1002, 32'h12345678);   // misaligned write
    xact(1'b1, 1'b0, 2'b11, 16'h0010, 32'h0);          // illegal mode
    xact(1'b0, 1'b1, 2'b01, 16'h0020, 32'hCAFEF00D);   // byte write rejected
    xact(1'b0, 1'b0, 2'b01, 16'h0003, 32'h0);          // signed byte read
    xact(1'b1, 1'b0, 2'b10, 16'h0201, 32'h0);          // unsigned byte read
    xact(1'b1, 1'b0, 2'b00, 16'h0006, 32'h0);          // misaligned read
    xact(1'b1, 1'b1, 2'b00, 16'h0008, 32'hA5A5_0F0F);  // second write

    // Reset during ACCESS aborts the transaction.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 2'b00, 16'h0040, 32'h11223344);
    w.addr = 16'h0040; w.wdata = 32'h11223344; w.cyc = cyc + 1;
    q_wr.push_back(w);
    @(posedge clk); #1;
    reset = 1'b1;
    m0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_write", {63'd0, mem_write}, 64'd0);
    check("abort_ack", {62'd0, m0_ack, m1_ack}, 64'd0);

    // Contention: both masters hold req; m0 drops after four grants.
    for (int k = 0; k < 5; k++) seq[k] = (k == 4) ? 1'b1 : (RR ? k[0] : 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 2'b00, 16'h0100, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 16'h0200, 32'h0);
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      e.m = seq[k]; e.err = 1'b0; e.cyc = c0 + 3 * k + 2;
      e.rdata = memfn(seq[k] ? 16'h0200 : 16'h0100, 2'b00);
      q_ack.push_back(e);
    end
    repeat (12) @(posedge clk);
    #1 m0_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 m1_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ack_queue_drained", q_ack.size(), 64'd0);
    check("write_queue_drained", q_wr.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
